// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction-fetch front end with a DEPTH-entry prefetch
// buffer. Requests go out in program order and responses return in the same
// order. Entries are allocated when a request is issued and filled when its
// response arrives. Decode consumes the oldest entry once it has been filled.
// A misaligned fetch address produces an exception entry and halts issue
// until the next flush. Responses to requests made before a flush are
// counted and then discarded.
module fetch_prefetch #(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter int                DEPTH       = 4,
    parameter int                EX_W        = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [EX_W-1:0]   EX_MISALIGN = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req_valid,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_req_ready,
    input  logic               mem_resp_valid,
    input  logic [INSTR_W-1:0] mem_resp_data,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [EX_W-1:0]    out_exception,
    output logic               out_exception_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // The outstanding-response counter is two bits wider than a pointer.
    // This leaves room when flushes are stacked on top of responses that
    // have not yet been drained.
    localparam int OUT_W = PTR_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(2 * DEPTH);

    // Scalar state
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  alloc_q, alloc_d;
    logic [PTR_W-1:0]  fill_q, fill_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  pend_q, pend_d;     // live requests still waiting for data
    logic [OUT_W-1:0]  drop_q, drop_d;     // pre-flush responses still to discard
    logic              halted_q, halted_d;

    // Buffer entries
    logic [ADDR_W-1:0]  pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [EX_W-1:0]    exc_q   [DEPTH];
    logic               excv_q  [DEPTH];
    logic               filled_q[DEPTH];

    // Decoded per-cycle events
    logic              aligned;
    logic              room;
    logic              req_valid;
    logic              issue;
    logic              misalign_alloc;
    logic              resp_drop;
    logic              resp_fill;
    logic              head_valid;
    logic              consume;
    logic [OUT_W-1:0]  total_out;
    logic [DEPTH-1:0]  alloc_we;
    logic [DEPTH-1:0]  fill_we;

    // Decode the issue, response and consume events for this cycle
    always_comb begin
        aligned   = (fetch_pc_q[1:0] == 2'b00);
        room      = !flush && !halted_q && (count_q < DEPTH_C);
        total_out = drop_q + OUT_W'(pend_q);
        // The outstanding bound only applies when flushes are stacked
        // back-to-back on slow memory. It never limits the normal flow.
        req_valid      = reset && room && aligned && (total_out < OUT_LIMIT);
        issue          = req_valid && mem_req_ready;
        misalign_alloc = room && !aligned;
        resp_drop      = mem_resp_valid && (drop_q != '0);
        resp_fill      = mem_resp_valid && (drop_q == '0) && (pend_q != '0);
        head_valid     = (count_q != '0) && filled_q[head_q];
        consume        = head_valid && !stall && !flush;
    end

    // Per-entry write enables for allocation and response fill
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign alloc_we[gi] = (issue || misalign_alloc) && (alloc_q == PTR_W'(gi));
            assign fill_we[gi]  = resp_fill && (fill_q == PTR_W'(gi));
        end
    endgenerate

    // Next state for the fetch PC, pointers, counters and halt flag
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        head_d     = head_q;
        count_d    = count_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        halted_d   = halted_q;
        if (flush) begin
            fetch_pc_d = flush_addr;
            alloc_d    = '0;
            fill_d     = '0;
            head_d     = '0;
            count_d    = '0;
            pend_d     = '0;
            halted_d   = 1'b0;
            // Every request still in flight becomes a drop. A response that
            // arrives in the flush cycle itself has already been discarded.
            drop_d     = total_out - OUT_W'(mem_resp_valid && (total_out != '0));
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                alloc_d    = alloc_q + 1'b1;
            end
            if (misalign_alloc) begin
                alloc_d  = alloc_q + 1'b1;
                halted_d = 1'b1;
            end
            if (resp_drop) begin
                drop_d = drop_q - 1'b1;
            end
            if (resp_fill) begin
                fill_d = fill_q + 1'b1;
            end
            if (consume) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(issue || misalign_alloc) - CNT_W'(consume);
            pend_d  = pend_q + CNT_W'(issue) - CNT_W'(resp_fill);
        end
    end

    // Scalar state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
        end
    end

    // Buffer entries: a flush invalidates them; otherwise allocate and fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                instr_q[i]  <= '0;
                exc_q[i]    <= '0;
                excv_q[i]   <= 1'b0;
                filled_q[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                filled_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_we[i]) begin
                    pc_q[i]     <= fetch_pc_q;
                    instr_q[i]  <= '0;
                    exc_q[i]    <= misalign_alloc ? EX_MISALIGN : '0;
                    excv_q[i]   <= misalign_alloc;
                    filled_q[i] <= misalign_alloc;
                end
                if (fill_we[i]) begin
                    instr_q[i]  <= mem_resp_data;
                    filled_q[i] <= 1'b1;
                end
            end
        end
    end

    assign mem_req_valid = req_valid;
    assign mem_req_addr  = fetch_pc_q;

    // The head-entry outputs are zero whenever the head entry is not deliverable.
    assign out_valid           = head_valid;
    assign out_instr           = head_valid ? instr_q[head_q] : '0;
    assign out_pc              = head_valid ? pc_q[head_q]    : '0;
    assign out_exception       = head_valid ? exc_q[head_q]   : '0;
    assign out_exception_valid = head_valid && excv_q[head_q];

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed testbench for fetch_prefetch. It uses an in-order memory model
// with programmable latency and a program-order delivery scoreboard. A
// cycle-by-cycle vector table covers start-up and stall behaviour, and
// hand-written sequences cover flush, misalign and reset.
module tb_fetch_prefetch;

    localparam int          ADDR_W  = 32;
    localparam int          INSTR_W = 32;
    localparam int          DEPTH   = 4;
    localparam int          EX_W    = 4;
    localparam logic [3:0]  EXC     = 4'h5;

    logic               clk;
    logic               reset;
    logic               mem_req_valid;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_req_ready;
    logic               mem_resp_valid;
    logic [INSTR_W-1:0] mem_resp_data;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [EX_W-1:0]    out_exception;
    logic               out_exception_valid;
    logic               stall;
    logic               flush;
    logic [ADDR_W-1:0]  flush_addr;

    fetch_prefetch #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .EX_W(EX_W),
        .RESET_PC(32'h0), .EX_MISALIGN(EXC)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_exception(out_exception), .out_exception_valid(out_exception_valid),
        .stall(stall), .flush(flush), .flush_addr(flush_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory model state
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          lat;
    int          cyc;
    int          max_out;

    // Scoreboard state
    logic [31:0] exp_pc;
    int          delivered;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] ra;
        logic        ov;
        logic [31:0] opc;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock. This captures the handshakes seen before the edge,
    // runs the scoreboard, updates the memory model, then returns at the
    // falling edge.
    task automatic step();
        logic        acc;
        logic        rsp;
        logic [31:0] a;
        #1;
        acc = mem_req_valid && mem_req_ready;
        a   = mem_req_addr;
        rsp = mem_resp_valid;
        if (out_valid && !stall && !flush) begin
            check("deliver_pc", out_pc, exp_pc);
            check("deliver_instr", out_instr, mem_word(exp_pc));
            $display("[TB] t=%0t deliver pc=0x%08h instr=0x%08h", $time, out_pc, out_instr);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (flush) exp_pc = flush_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (acc) begin
            q_addr.push_back(a);
            q_due.push_back(cyc + lat);
        end
        if (q_addr.size() > max_out) max_out = q_addr.size();
        if (q_due.size() > 0 && q_due[0] <= cyc + 1) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(q_addr[0]);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0; flush = 1'b0; flush_addr = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        q_addr.delete(); q_due.delete();
        cyc = 0; exp_pc = '0; delivered = 0; max_out = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int d0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; flush_addr = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        lat = 1;

        // Row r is checked after edge r. Its stall value is driven for edge r+1.
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[6]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        tbl[7]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
        tbl[8]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        tbl[9]  = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
        tbl[10] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h18};

        // Reset state
        #1;
        check("reset_req_valid", mem_req_valid, 0);
        check("reset_out_valid", out_valid, 0);

        // Vector table: latency 1, with a short stall that fills the buffer
        lat = 1;
        do_reset();
        for (int r = 0; r < 11; r++) begin
            #1;
            check("tbl_req_valid", mem_req_valid, tbl[r].rv);
            check("tbl_req_addr", mem_req_addr, tbl[r].ra);
            check("tbl_out_valid", out_valid, tbl[r].ov);
            check("tbl_out_pc", out_pc, tbl[r].opc);
            check("tbl_out_instr", out_instr, tbl[r].ov ? mem_word(tbl[r].opc) : 32'h0);
            check("tbl_exc_valid", out_exception_valid, 0);
            $display("[TB] row %0d req=%0b/0x%0h out=%0b pc=0x%0h", r, mem_req_valid,
                     mem_req_addr, out_valid, out_pc);
            stall = tbl[r].stall;
            step();
        end

        // Full buffer held under stall for 5 cycles, then resume
        lat = 1;
        do_reset();
        stall = 1'b1;
        repeat (6) step();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_req_valid", mem_req_valid, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_pc", out_pc, 32'h0);
            check("stall_out_instr", out_instr, mem_word(32'h0));
            step();
        end
        stall = 1'b0;
        delivered = 0;
        repeat (12) step();
        check("stall_resume_count", delivered, 12);
        check("stall_resume_pc", exp_pc, 32'd48);

        // Latency 6 with a gappy ready: outstanding requests capped at DEPTH
        lat = 6;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            mem_req_ready = (k % 3 != 2);
            step();
        end
        mem_req_ready = 1'b1;
        check("l6_max_outstanding", max_out, DEPTH);
        check("l6_progress", delivered >= 15, 1);

        // Flush with 3 requests in flight and a response in the flush cycle
        lat = 3;
        do_reset();
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (q_addr.size() == 3 && mem_resp_valid) found = 1;
        end
        check("flush_setup_found", found, 1);
        flush = 1'b1; flush_addr = 32'h100;
        step();
        flush = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_req_valid", mem_req_valid, 1);
        check("flush_req_addr", mem_req_addr, 32'h100);
        d0 = delivered;
        repeat (15) step();
        check("flush_delivered", (delivered - d0) >= 3, 1);

        // Misaligned redirect: exception entry, halted issue, then recovery
        stall = 1'b1;
        flush = 1'b1; flush_addr = 32'h102;
        step();
        flush = 1'b0;
        #1;
        check("mis_req_valid0", mem_req_valid, 0);
        check("mis_out_valid0", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            check("mis_out_valid", out_valid, 1);
            check("mis_exc_valid", out_exception_valid, 1);
            check("mis_exc_code", out_exception, EXC);
            check("mis_out_pc", out_pc, 32'h102);
            check("mis_out_instr", out_instr, 32'h0);
            check("mis_req_halted", mem_req_valid, 0);
        end
        flush = 1'b1; flush_addr = 32'h200;
        step();
        flush = 1'b0;
        #1;
        check("mis_resume_req_valid", mem_req_valid, 1);
        check("mis_resume_req_addr", mem_req_addr, 32'h200);
        stall = 1'b0;
        d0 = delivered;
        repeat (12) step();
        check("mis_resume_delivered", (delivered - d0) >= 3, 1);

        // Reset asserted mid-stream with requests in flight
        check("pre_reset_inflight", q_addr.size() > 0, 1);
        reset = 1'b0;
        #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_exc", out_exception, 4'h0);
        check("rst_out_exc_valid", out_exception_valid, 0);
        q_addr.delete(); q_due.delete();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        lat = 1; exp_pc = '0; delivered = 0;
        #1;
        check("post_rst_req_valid", mem_req_valid, 1);
        check("post_rst_req_addr", mem_req_addr, 32'h0);
        repeat (8) step();
        check("post_rst_delivered", delivered, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
